// File: rtl/mem_stage.sv
// Memory-access stage: drives a req/ack data port, formats loads and stores,
// stalls upstream while an access is outstanding, registers write-back results.
module mem_stage #(
    parameter bit ACK_IN_IDLE_IGNORE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic [31:0] wb_data,
    output logic        mem_fault
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_off;
    logic [4:0]  cap_rd;
    logic        cap_regwrite;

    logic        memop;
    logic        bad_funct3;
    logic        misaligned;
    logic        fault;
    logic        ack_seen;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] rd_shifted;
    logic [31:0] ld_data;

    // Classify the EX instruction and decide whether it must be killed
    assign memop      = ex_valid & (ex_mem_rd | ex_mem_wr);
    assign bad_funct3 = (ex_funct3 == 3'b011) | (ex_funct3 == 3'b110) |
                        (ex_funct3 == 3'b111) | (ex_mem_wr & ex_funct3[2]);
    assign misaligned = ((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                        ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
    assign fault      = memop & ((ex_mem_rd & ex_mem_wr) | bad_funct3 | misaligned);

    // An ack only counts while an access is outstanding
    assign ack_seen = dmem_ack & ((state == WAIT) | !ACK_IN_IDLE_IGNORE);

    // Hold upstream while a request is being launched or is still in flight
    assign stall = ((state == IDLE) & memop & !fault) | ((state == WAIT) & !ack_seen);

    // Store lane placement and data replication
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
        case (ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'(4'b0001 << ex_addr[1:0]);
                st_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_wdata;
            end
        endcase
    end

    // Load lane select and extension using the captured offset and funct3
    assign rd_shifted = dmem_rdata >> {cap_off, 3'b000};

    always_comb begin
        ld_data = dmem_rdata;
        case (cap_funct3)
            3'b000:  ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  ld_data = {24'd0, rd_shifted[7:0]};
            3'b101:  ld_data = {16'd0, rd_shifted[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Stage FSM with registered memory-port and write-back outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cap_funct3   <= 3'd0;
            cap_off      <= 2'd0;
            cap_rd       <= 5'd0;
            cap_regwrite <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            dmem_be      <= 4'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_regwrite  <= 1'b0;
            wb_data      <= 32'd0;
            mem_fault    <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (fault) begin
                        mem_fault <= 1'b1;
                    end else if (memop) begin
                        cap_funct3   <= ex_funct3;
                        cap_off      <= ex_addr[1:0];
                        cap_rd       <= ex_rd;
                        cap_regwrite <= ex_regwrite;
                        dmem_req     <= 1'b1;
                        dmem_we      <= ex_mem_wr;
                        dmem_addr    <= {ex_addr[31:2], 2'b00};
                        dmem_wdata   <= ex_mem_wr ? st_wdata : 32'd0;
                        dmem_be      <= ex_mem_wr ? st_be : 4'b1111;
                        state        <= WAIT;
                    end else if (ex_valid) begin
                        wb_valid    <= 1'b1;
                        wb_rd       <= ex_rd;
                        wb_regwrite <= ex_regwrite;
                        wb_data     <= ex_addr;
                    end
                end
                WAIT: begin
                    if (ack_seen) begin
                        state       <= IDLE;
                        dmem_req    <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_rd       <= cap_rd;
                        wb_regwrite <= dmem_we ? 1'b0 : cap_regwrite;
                        wb_data     <= dmem_we ? 32'd0 : ld_data;
                    end
                end
            endcase
        end
    end

endmodule
